// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router control path: FSM state
// encoding, the reserved header address and the destination count.
package router_pkg;

    localparam int NUM_PORTS = 3;

    // Address value 3 has no FIFO behind it; such headers are dropped.
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DA  = 3'd0,   // DECODE_ADDRESS
        LFD = 3'd1,   // LOAD_FIRST_DATA
        LD  = 3'd2,   // LOAD_DATA
        LP  = 3'd3,   // LOAD_PARITY
        FFS = 3'd4,   // FIFO_FULL_STATE
        LAF = 3'd5,   // LOAD_AFTER_FULL
        WTE = 3'd6,   // WAIT_TILL_EMPTY
        CPE = 3'd7    // CHECK_PARITY_ERROR
    } state_t;

endpackage

// File: rtl/router_fsm.sv
// Ingress control FSM of the 1x3 router. Decodes the header address,
// sequences writes into the addressed output FIFO, and handles FIFO-full
// back-pressure, parity loading and per-port soft-reset aborts.
// All outputs are Moore outputs decoded from the state register.
// Optional feature: define ROUTER_FSM_PKT_CNT_EN to add per-port
// completed-packet counters on the pkt_cnt port.
module router_fsm #(
    parameter int NUM_PORTS = 3
`ifdef ROUTER_FSM_PKT_CNT_EN
   ,parameter int CNT_W     = 8
`endif
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   pkt_valid,
    input  logic [1:0]             addr_in,
    input  logic [NUM_PORTS-1:0]   fifo_full,
    input  logic [NUM_PORTS-1:0]   fifo_empty,
    input  logic [NUM_PORTS-1:0]   soft_reset,
    input  logic                   parity_done,
    input  logic                   low_pkt_valid,
    output logic [NUM_PORTS-1:0]   write_enb,
    output logic                   detect_add,
    output logic                   lfd_state,
    output logic                   ld_state,
    output logic                   laf_state,
    output logic                   full_state,
    output logic                   rst_int_reg,
    output logic                   busy
`ifdef ROUTER_FSM_PKT_CNT_EN
   ,output logic [NUM_PORTS*CNT_W-1:0] pkt_cnt
`endif
);

    import router_pkg::*;

    state_t     state;
    state_t     next_state;
    logic [1:0] addr_q;
    logic [1:0] sel_addr;
    logic       f_full;
    logic       f_empty;
    logic       f_srst;
    logic       wr_active;

    // Port flags follow the live header address while decoding, and the
    // latched address for the rest of the packet. Address 3 selects nothing.
    always_comb begin
        sel_addr = (state == DA) ? addr_in : addr_q;
        f_full   = 1'b0;
        f_empty  = 1'b0;
        f_srst   = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel_addr == 2'(i)) begin
                f_full  = fifo_full[i];
                f_empty = fifo_empty[i];
                f_srst  = soft_reset[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= DA;
        else         state <= next_state;
    end

    // Latch the destination of each accepted header.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            addr_q <= 2'b00;
        else if (state == DA && pkt_valid && addr_in != ADDR_INVALID)
            addr_q <= addr_in;
    end

    // Next-state logic; a soft reset on the active port overrides everything.
    always_comb begin
        next_state = state;
        case (state)
            DA: begin
                if (pkt_valid && addr_in != ADDR_INVALID)
                    next_state = f_empty ? LFD : WTE;
            end
            LFD: next_state = LD;
            LD: begin
                if (f_full)          next_state = FFS;
                else if (!pkt_valid) next_state = LP;
            end
            LP:  next_state = CPE;
            CPE: next_state = f_full ? FFS : DA;
            FFS: begin
                if (!f_full) next_state = LAF;
            end
            LAF: begin
                if (parity_done)        next_state = DA;
                else if (low_pkt_valid) next_state = LP;
                else                    next_state = LD;
            end
            WTE: begin
                if (f_empty) next_state = LFD;
            end
            default: next_state = DA;
        endcase
        if (state != DA && f_srst)
            next_state = DA;
    end

    // Moore output decode; write enable is one-hot on the latched port.
    always_comb begin
        detect_add  = (state == DA);
        lfd_state   = (state == LFD);
        ld_state    = (state == LD);
        laf_state   = (state == LAF);
        full_state  = (state == FFS);
        rst_int_reg = (state == CPE);
        busy        = (state == LFD) || (state == LP)  || (state == CPE) ||
                      (state == FFS) || (state == LAF) || (state == WTE);
        wr_active   = (state == LFD) || (state == LD) ||
                      (state == LP)  || (state == LAF);
        write_enb   = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            write_enb[i] = wr_active && (addr_q == 2'(i));
    end

`ifdef ROUTER_FSM_PKT_CNT_EN
    logic [NUM_PORTS-1:0][CNT_W-1:0] cnt;
    logic                            cnt_inc;

    // A packet completes when CPE or LAF returns to DA on its own, not by abort.
    always_comb begin
        cnt_inc = !f_srst &&
                  (((state == CPE) && !f_full) || ((state == LAF) && parity_done));
    end

    // Per-port completed-packet counters, wrapping, cleared only by resetn.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            for (int i = 0; i < NUM_PORTS; i++)
                if (addr_q == 2'(i))
                    cnt[i] <= cnt[i] + 1'b1;
        end
    end

    assign pkt_cnt = cnt;
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm. Outputs are sampled 1 ns after each
// rising edge and compared against hand-derived per-state values.
module tb_router_fsm;

    localparam int CNT_W = 8;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] addr_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] soft_reset;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [2:0] write_enb;
    logic       detect_add, lfd_state, ld_state, laf_state;
    logic       full_state, rst_int_reg, busy;
`ifdef ROUTER_FSM_PKT_CNT_EN
    logic [3*CNT_W-1:0] pkt_cnt;
`endif

    int total = 0;
    int bad   = 0;

    router_fsm dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .addr_in       (addr_in),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .soft_reset    (soft_reset),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .write_enb     (write_enb),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy)
`ifdef ROUTER_FSM_PKT_CNT_EN
       ,.pkt_cnt       (pkt_cnt)
`endif
    );

    always #5 clock = ~clock;

    // Bench-side state labels for building expected output vectors.
    localparam int E_DA = 0, E_LFD = 1, E_LD = 2, E_LP = 3,
                   E_FFS = 4, E_LAF = 5, E_WTE = 6, E_CPE = 7;

    // Expected {detect_add,lfd,ld,laf,full,rst_int_reg,busy,write_enb[2:0]}.
    function automatic logic [9:0] exp_out(int st, int port);
        logic [2:0] we;
        we = 3'b001 << port;
        case (st)
            E_DA:  exp_out = 10'b1000000_000;
            E_LFD: exp_out = {7'b0100001, we};
            E_LD:  exp_out = {7'b0010000, we};
            E_LP:  exp_out = {7'b0000001, we};
            E_FFS: exp_out = 10'b0000101_000;
            E_LAF: exp_out = {7'b0001001, we};
            E_WTE: exp_out = 10'b0000001_000;
            E_CPE: exp_out = 10'b0000011_000;
            default: exp_out = 10'b0;
        endcase
    endfunction

    function automatic logic [9:0] obs_out();
        obs_out = {detect_add, lfd_state, ld_state, laf_state, full_state,
                   rst_int_reg, busy, write_enb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic step_chk(input string tag, input int st, input int port);
        step();
        chk(tag, 32'(obs_out()), 32'(exp_out(st, port)));
    endtask

`ifdef ROUTER_FSM_PKT_CNT_EN
    task automatic chk_cnt(input string tag, input int port, input int exp);
        chk(tag, 32'(pkt_cnt[port*CNT_W +: CNT_W]), 32'(exp));
    endtask
`endif

    initial begin
        resetn = 1'b0; pkt_valid = 1'b0; addr_in = 2'd0;
        fifo_full = 3'b000; fifo_empty = 3'b111; soft_reset = 3'b000;
        parity_done = 1'b0; low_pkt_valid = 1'b0;
        #12;
        chk("reset_outputs", 32'(obs_out()), 32'(exp_out(E_DA, 0)));
`ifdef ROUTER_FSM_PKT_CNT_EN
        chk("reset_cnt", 32'(pkt_cnt), 32'(0));
`endif
        resetn = 1'b1;
        step_chk("idle_da", E_DA, 0);

        // Packet to port 1 with empty FIFO: header + 4 bytes, then parity.
        pkt_valid = 1'b1; addr_in = 2'd1;
        step_chk("p1_lfd", E_LFD, 1);
        for (int i = 0; i < 4; i++) step_chk("p1_ld", E_LD, 1);
        pkt_valid = 1'b0;
        step_chk("p1_lp", E_LP, 1);
        step_chk("p1_cpe", E_CPE, 1);
        step_chk("p1_da", E_DA, 0);
`ifdef ROUTER_FSM_PKT_CNT_EN
        chk_cnt("p1_cnt", 1, 1);
`endif

        // Port 2 not empty: wait, then load once it drains.
        pkt_valid = 1'b1; addr_in = 2'd2; fifo_empty = 3'b011;
        for (int i = 0; i < 5; i++) step_chk("p2_wte", E_WTE, 2);
        fifo_empty = 3'b111;
        step_chk("p2_lfd", E_LFD, 2);
        step_chk("p2_ld", E_LD, 2);
        pkt_valid = 1'b0;
        step_chk("p2_lp", E_LP, 2);
        step_chk("p2_cpe", E_CPE, 2);
        step_chk("p2_da", E_DA, 0);
`ifdef ROUTER_FSM_PKT_CNT_EN
        chk_cnt("p2_cnt", 2, 1);
`endif

        // Port 0 back-pressure, resumed with low_pkt_valid.
        pkt_valid = 1'b1; addr_in = 2'd0;
        step_chk("p0a_lfd", E_LFD, 0);
        step_chk("p0a_ld", E_LD, 0);
        fifo_full = 3'b001;
        for (int i = 0; i < 3; i++) step_chk("p0a_ffs", E_FFS, 0);
        fifo_full = 3'b000;
        step_chk("p0a_laf", E_LAF, 0);
        pkt_valid = 1'b0; low_pkt_valid = 1'b1;
        step_chk("p0a_lp", E_LP, 0);
        low_pkt_valid = 1'b0;
        step_chk("p0a_cpe", E_CPE, 0);
        step_chk("p0a_da", E_DA, 0);
`ifdef ROUTER_FSM_PKT_CNT_EN
        chk_cnt("p0a_cnt", 0, 1);
`endif

        // Full and pkt_valid fall together: full wins; LAF exits via parity_done.
        pkt_valid = 1'b1; addr_in = 2'd0;
        step_chk("p0b_lfd", E_LFD, 0);
        step_chk("p0b_ld", E_LD, 0);
        fifo_full = 3'b001; pkt_valid = 1'b0;
        step_chk("p0b_ffs", E_FFS, 0);
        fifo_full = 3'b000;
        step_chk("p0b_laf", E_LAF, 0);
        parity_done = 1'b1;
        step_chk("p0b_da", E_DA, 0);
        parity_done = 1'b0;
`ifdef ROUTER_FSM_PKT_CNT_EN
        chk_cnt("p0b_cnt", 0, 2);
`endif

        // Soft reset: other port ignored, addressed port aborts.
        pkt_valid = 1'b1; addr_in = 2'd0;
        step_chk("p0c_lfd", E_LFD, 0);
        step_chk("p0c_ld", E_LD, 0);
        soft_reset = 3'b010;
        step_chk("srst_other", E_LD, 0);
        soft_reset = 3'b001;
        step_chk("srst_abort", E_DA, 0);
        soft_reset = 3'b000; pkt_valid = 1'b0;
        step_chk("srst_idle", E_DA, 0);
`ifdef ROUTER_FSM_PKT_CNT_EN
        chk_cnt("srst_cnt", 0, 2);
`endif

        // Invalid header address is ignored.
        pkt_valid = 1'b1; addr_in = 2'd3;
        step_chk("addr3_a", E_DA, 0);
        step_chk("addr3_b", E_DA, 0);

        // Asynchronous reset mid-LD, then a fresh header.
        addr_in = 2'd2;
        step_chk("rst_lfd", E_LFD, 2);
        step_chk("rst_ld", E_LD, 2);
        #2 resetn = 1'b0;
        #1 chk("async_reset", 32'(obs_out()), 32'(exp_out(E_DA, 0)));
`ifdef ROUTER_FSM_PKT_CNT_EN
        chk("async_reset_cnt", 32'(pkt_cnt), 32'(0));
`endif
        step_chk("held_reset", E_DA, 0);
        resetn = 1'b1; addr_in = 2'd1;
        step_chk("post_rst_lfd", E_LFD, 1);
        step_chk("post_rst_ld", E_LD, 1);
        pkt_valid = 1'b0;
        step_chk("post_rst_lp", E_LP, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Control FSM for the 1x3 router ingress path.
- Decodes the header address of each incoming packet and sequences writes into one of three 8-bit output FIFOs.
- Handles FIFO-full back-pressure, parity-byte loading and per-port soft-reset aborts.
- Sits between the ingress register block and the three FIFOs; drives one-hot write enables and the FIFO's lfd_state input.

Parameters:
- NUM_PORTS, 3, number of destination FIFOs; the address field is 2 bits, so values 0..2 are valid.
- CNT_W, 8, width of each per-port packet counter (optional feature only).

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- pkt_valid  in  1  high while the sender drives header or payload bytes; falls with the parity byte.
- addr_in  in  2  header bits [1:0], sampled in DECODE_ADDRESS.
- fifo_full  in  3  per-port FIFO full flags.
- fifo_empty  in  3  per-port FIFO empty flags.
- soft_reset  in  3  per-port soft-reset (timeout) pulses.
- parity_done  in  1  from the register block: parity byte has been written.
- low_pkt_valid  in  1  from the register block: pkt_valid fell while the FIFO was full.
- write_enb  out  3  one-hot FIFO write enable, indexed by the latched address.
- detect_add  out  1  state is DECODE_ADDRESS.
- lfd_state  out  1  state is LOAD_FIRST_DATA.
- ld_state  out  1  state is LOAD_DATA.
- laf_state  out  1  state is LOAD_AFTER_FULL.
- full_state  out  1  state is FIFO_FULL_STATE.
- rst_int_reg  out  1  state is CHECK_PARITY_ERROR.
- busy  out  1  sender must hold data.
- pkt_cnt  out  3*CNT_W  per-port packet counters; exists only with the optional feature.

Behaviour:
- State register is updated on the rising edge of clock. resetn low forces DECODE_ADDRESS asynchronously and clears the latched address to 0.
- Reset output values: detect_add=1; all other outputs 0.
- All outputs are Moore (decoded from state only).
- addr_q latches addr_in when state is DECODE_ADDRESS, pkt_valid=1 and addr_in != 3.
- f_full, f_empty and f_srst denote fifo_full, fifo_empty and soft_reset indexed by addr_q, or by addr_in while in DECODE_ADDRESS.
- DECODE_ADDRESS (DA): busy=0.
  - pkt_valid and addr_in==3: stay in DA (header ignored).
  - pkt_valid and f_empty: go to LFD.
  - pkt_valid and !f_empty: go to WTE.
  - Otherwise stay in DA.
- LOAD_FIRST_DATA (LFD): write_enb[addr_q]=1, busy=1; always go to LD.
- LOAD_DATA (LD): write_enb=1, busy=0.
  - f_full: go to FFS.
  - else !pkt_valid: go to LP.
  - else stay in LD.
- LOAD_PARITY (LP): write_enb=1, busy=1; always go to CPE.
- CHECK_PARITY_ERROR (CPE): busy=1. f_full goes to FFS; otherwise DA.
- FIFO_FULL_STATE (FFS): write_enb=0, busy=1. !f_full goes to LAF; otherwise stay.
- LOAD_AFTER_FULL (LAF): write_enb=1, busy=1.
  - parity_done: go to DA.
  - else low_pkt_valid: go to LP.
  - else go to LD.
- WAIT_TILL_EMPTY (WTE): busy=1, write_enb=0. f_empty goes to LFD; otherwise stay.
- Soft-reset abort: f_srst=1 in any state other than DA forces DA on the next edge, overriding all other transitions. soft_reset on a non-addressed port has no effect.
- write_enb is never multi-hot and is 0 in DA, FFS, WTE and CPE.
- If pkt_valid falls in the same cycle LD sees f_full, f_full wins (go to FFS).
- resetn asserted mid-packet: immediate return to DA; no partial write occurs after reset.

Optional Feature:
- Macro: ROUTER_FSM_PKT_CNT_EN.
- Defined: the pkt_cnt port exists. The counter for addr_q increments by 1 on every exit from CPE or LAF to DA that is not caused by f_srst. Counters wrap modulo 2^CNT_W and are cleared by resetn only.
- Undefined: no counters and no pkt_cnt port; all other behaviour is identical.

Decomposition:
- Shared package router_pkg holds:
  - state enum: DA, LFD, LD, LP, FFS, LAF, WTE, CPE, 3-bit encoding;
  - constant ADDR_INVALID=2'b11;
  - constant NUM_PORTS=3.
- No sub-module: next-state logic, output decode and optional counters stay in one module.

Test Plan:
- Reset, then pkt_valid=1 with addr_in=1 and fifo_empty=3'b111: DA, then LFD with write_enb=3'b010 and lfd_state=1, then LD. Drop pkt_valid after 4 bytes: LP, then CPE, then DA. pkt_cnt[1]=1 with the feature on.
- addr_in=2 with fifo_empty[2]=0: WTE with busy=1, held 5 cycles. Raise fifo_empty[2]: LFD next cycle, write_enb=3'b100.
- In LD on port 0, raise fifo_full[0]: FFS with write_enb=0 and busy=1. Clear fifo_full after 3 cycles: LAF. low_pkt_valid=1 then goes to LP, then CPE, then DA.
- In LD on port 0, pulse soft_reset[1]: no effect. Pulse soft_reset[0]: DA next cycle, pkt_cnt[0] unchanged.
- pkt_valid=1 with addr_in=3: remains in DA, write_enb=0, detect_add=1.
- Deassert resetn asynchronously mid-LD: outputs go to reset values immediately; after release, the FSM accepts a new header normally.
